bram_sdp_mem: RTL

BRAM_SDP_MEM -- requirements
Module: bram_sdp_mem

---
 rtl/bram_sdp_mem.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bram_sdp_mem.sv
// Simple dual-port block RAM: one write port with byte enables, one registered read port,
// write-first on address collision. Define BRAM_SDP_OUTPUT_REG_EN to add a second read stage.
module bram_sdp_mem #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    ready
);
    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    typedef enum logic {StClear, StRun} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q;
    logic                    ready_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    run;
    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    user_wr;
    logic                    rd_fire;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   s1_data_q;
    logic                    s1_valid_q;

    assign run         = (state_q == StRun) && !rst;
    assign wr_in_range = {1'b0, wr_addr} < (ADDR_WIDTH + 1)'(DEPTH);
    assign rd_in_range = {1'b0, rd_addr} < (ADDR_WIDTH + 1)'(DEPTH);
    assign user_wr     = run && wr_en && wr_in_range;
    assign rd_fire     = run && rd_en;
    assign ready       = ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                StClear: begin
                    if (clr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                StRun: ready_q <= 1'b1;
                default: state_q <= StRun;
            endcase
        end
    end

    // Fill and user writes share the single write port; the fill owns it while clearing.
    always_ff @(posedge clk) begin
        if (!rst && state_q == StClear) begin
            mem[clr_ptr_q] <= '0;
        end else if (user_wr) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Write-first: enabled bytes of a colliding write replace the stored bytes.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
            if (user_wr && wr_addr == rd_addr) begin
                for (int i = 0; i < NumBytes; i++) begin
                    if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_fire;
            if (rd_fire) s1_data_q <= rd_word;
        end
    end

`ifdef BRAM_SDP_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] s2_data_q;
    logic                  s2_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_data_q  <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) s2_data_q <= s1_data_q;
        end
    end

    assign rd_data  = s2_data_q;
    assign rd_valid = s2_valid_q;
`else
    assign rd_data  = s1_data_q;
    assign rd_valid = s1_valid_q;
`endif

endmodule
